pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline control unit for the 5-stage core. Replaces the fixed hazard and forwarding pair.
- Adds real load-use detection, a bounded memory-wait FSM with timeout, and an interrupt-entry FSM with masking and a latched pending alert.
- Adds saturating stall/flush performance counters.
- Sits beside the four pipeline buffers; drives their stall/flush inputs and the EX operand-forwarding selects.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_fwd_mux.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

   typedef enum logic {
      M_IDLE,
      M_WAIT
   } mem_state_e;

   typedef enum logic [1:0] {
      I_IDLE,
      I_PEND,
      I_TAKE,
      I_MASKED
   } irq_state_e;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_MEM  = 2'b01,
      FWD_WB   = 2'b10
   } fwd_sel_e;

   localparam int unsigned NUM_BUF    = 4;
   localparam int unsigned BUF_IF_ID  = 0;
   localparam int unsigned BUF_ID_EX  = 1;
   localparam int unsigned BUF_EX_MEM = 2;
   localparam int unsigned BUF_MEM_WB = 3;

endpackage

// File: rtl/pipe_fwd_mux.sv
// Per-operand forwarding: match EX source against MEM/WB destinations, MEM wins.
module pipe_fwd_mux
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 4,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic [REG_AW-1:0] ex_rs_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              mem_reg_wr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_reg_wr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [1:0]        sel_o,
   output logic [DATA_W-1:0] data_o
);

   logic rs_ok;
   logic mem_hit;
   logic wb_hit;

   assign rs_ok   = (ZERO_REG == 0) || (ex_rs_i != '0);
   assign mem_hit = rs_ok && mem_reg_wr_i && (mem_rd_i == ex_rs_i);
   assign wb_hit  = rs_ok && wb_reg_wr_i && (wb_rd_i == ex_rs_i);

   always_comb begin
      sel_o  = FWD_NONE;
      data_o = '0;
      if (mem_hit) begin
         sel_o  = FWD_MEM;
         data_o = mem_data_i;
      end else if (wb_hit) begin
         sel_o  = FWD_WB;
         data_o = wb_data_i;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: hazard priority, memory-wait and interrupt-entry FSMs,
// EX operand forwarding and saturating stall/flush counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned REG_AW      = 4,
   parameter int unsigned ZERO_REG    = 0,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_wr,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_wr,
   input  logic              mem_is_load,
   input  logic [DATA_W-1:0] mem_alu_data,
   input  logic [DATA_W-1:0] mem_load_data,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_reg_wr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mem_req,
   input  logic              mem_valid,
   input  logic              branch_miss,
   input  logic              id_redirect,
   input  logic              alert,
   input  logic              reti,
   output logic [3:0]        stall,
   output logic [3:0]        flush,
   output logic              pc_hold,
   output logic [1:0]        rs1_fwd_sel,
   output logic [1:0]        rs2_fwd_sel,
   output logic [DATA_W-1:0] rs1_fwd_data,
   output logic [DATA_W-1:0] rs2_fwd_data,
   output logic              irq_take,
   output logic              irq_masked,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

   mem_state_e        mem_state_q, mem_state_d;
   irq_state_e        irq_state_q, irq_state_d;
   logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
   logic              mem_err_q, mem_err_d;
   logic              irq_take_q, irq_take_d;
   logic              pending_q, pending_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
   logic              mem_wait;
   logic              load_use;
   logic              rd_ok;
   logic [DATA_W-1:0] mem_data;

   // ---------------- forwarding ----------------
   assign mem_data = mem_is_load ? mem_load_data : mem_alu_data;

   pipe_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_rs1 (
      .ex_rs_i      (ex_rs1),
      .mem_rd_i     (mem_rd),
      .mem_reg_wr_i (mem_reg_wr),
      .mem_data_i   (mem_data),
      .wb_rd_i      (wb_rd),
      .wb_reg_wr_i  (wb_reg_wr),
      .wb_data_i    (wb_data),
      .sel_o        (rs1_fwd_sel),
      .data_o       (rs1_fwd_data)
   );

   pipe_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_rs2 (
      .ex_rs_i      (ex_rs2),
      .mem_rd_i     (mem_rd),
      .mem_reg_wr_i (mem_reg_wr),
      .mem_data_i   (mem_data),
      .wb_rd_i      (wb_rd),
      .wb_reg_wr_i  (wb_reg_wr),
      .wb_data_i    (wb_data),
      .sel_o        (rs2_fwd_sel),
      .data_o       (rs2_fwd_data)
   );

   // ---------------- load-use ----------------
   assign rd_ok    = (ZERO_REG == 0) || (ex_rd != '0);
   assign load_use = ex_is_load && ex_reg_wr && rd_ok &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

   // ---------------- memory-wait FSM ----------------
   // The cycle after a timeout ignores mem_req so the abandoned access
   // releases the pipeline even if the requester has not yet dropped it.
   always_comb begin
      mem_state_d = mem_state_q;
      tmo_d       = tmo_q;
      mem_err_d   = 1'b0;
      mem_wait    = 1'b0;
      tmo_inc     = tmo_q + TW'(1);
      unique case (mem_state_q)
         M_IDLE: begin
            if (mem_req && !mem_valid && !mem_err_q) begin
               mem_wait = 1'b1;
               if (tmo_inc == TW'(MEM_TIMEOUT)) begin
                  mem_err_d = 1'b1;
                  tmo_d     = '0;
               end else begin
                  mem_state_d = M_WAIT;
                  tmo_d       = tmo_inc;
               end
            end
         end
         M_WAIT: begin
            if (mem_valid) begin
               mem_state_d = M_IDLE;
               tmo_d       = '0;
            end else begin
               mem_wait = 1'b1;
               if (tmo_inc == TW'(MEM_TIMEOUT)) begin
                  mem_state_d = M_IDLE;
                  mem_err_d   = 1'b1;
                  tmo_d       = '0;
               end else begin
                  tmo_d = tmo_inc;
               end
            end
         end
      endcase
   end

   // ---------------- interrupt-entry FSM ----------------
   always_comb begin
      irq_state_d = irq_state_q;
      pending_d   = pending_q;
      unique case (irq_state_q)
         I_IDLE: begin
            if (alert || pending_q) irq_state_d = I_PEND;
         end
         I_PEND: begin
            if (!mem_wait && !branch_miss) irq_state_d = I_TAKE;
         end
         I_TAKE: begin
            pending_d   = 1'b0;
            irq_state_d = I_MASKED;
         end
         I_MASKED: begin
            if (alert) pending_d = 1'b1;
            if (reti) irq_state_d = I_IDLE;
         end
      endcase
      irq_take_d = (irq_state_d == I_TAKE);
   end

   assign irq_masked = (irq_state_q == I_TAKE) || (irq_state_q == I_MASKED);
   assign irq_take   = irq_take_q;
   assign mem_err    = mem_err_q;

   // ---------------- hazard priority ----------------
   always_comb begin
      stall   = '0;
      flush   = '0;
      pc_hold = 1'b0;
      if (!rst_n) begin
         flush   = '1;
         pc_hold = 1'b1;
      end else if (mem_wait) begin
         stall   = '1;
         pc_hold = 1'b1;
      end else if (branch_miss || irq_take_q) begin
         flush[BUF_IF_ID] = 1'b1;
         flush[BUF_ID_EX] = 1'b1;
      end else if (load_use) begin
         pc_hold          = 1'b1;
         stall[BUF_IF_ID] = 1'b1;
         flush[BUF_ID_EX] = 1'b1;
      end else if (id_redirect) begin
         flush[BUF_IF_ID] = 1'b1;
      end
   end

   // ---------------- state and counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_state_q <= M_IDLE;
         irq_state_q <= I_IDLE;
         tmo_q       <= '0;
         mem_err_q   <= 1'b0;
         irq_take_q  <= 1'b0;
         pending_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         mem_state_q <= mem_state_d;
         irq_state_q <= irq_state_d;
         tmo_q       <= tmo_d;
         mem_err_q   <= mem_err_d;
         irq_take_q  <= irq_take_d;
         pending_q   <= pending_d;
         if (pc_hold && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if ((flush != '0) && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (ZERO_REG=1, MEM_TIMEOUT=15, 4-bit counters).
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic        id_rs1_used, id_rs2_used, ex_reg_wr, ex_is_load;
   logic        mem_reg_wr, mem_is_load, wb_reg_wr;
   logic [31:0] mem_alu_data, mem_load_data, wb_data;
   logic        mem_req, mem_valid, branch_miss, id_redirect, alert, reti;
   logic [3:0]  stall, flush;
   logic        pc_hold;
   logic [1:0]  rs1_fwd_sel, rs2_fwd_sel;
   logic [31:0] rs1_fwd_data, rs2_fwd_data;
   logic        irq_take, irq_masked, mem_err;
   logic [3:0]  stall_cnt, flush_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   pipe_hazard_ctrl #(
      .DATA_W(32), .REG_AW(4), .ZERO_REG(1), .MEM_TIMEOUT(15), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_is_load(mem_is_load),
      .mem_alu_data(mem_alu_data), .mem_load_data(mem_load_data),
      .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .wb_data(wb_data),
      .mem_req(mem_req), .mem_valid(mem_valid),
      .branch_miss(branch_miss), .id_redirect(id_redirect),
      .alert(alert), .reti(reti),
      .stall(stall), .flush(flush), .pc_hold(pc_hold),
      .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
      .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
      .irq_take(irq_take), .irq_masked(irq_masked), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_wr = 1'b0; ex_is_load = 1'b0;
      mem_rd = '0; mem_reg_wr = 1'b0; mem_is_load = 1'b0;
      mem_alu_data = '0; mem_load_data = '0;
      wb_rd = '0; wb_reg_wr = 1'b0; wb_data = '0;
      mem_req = 1'b0; mem_valid = 1'b0; branch_miss = 1'b0; id_redirect = 1'b0;
      alert = 1'b0; reti = 1'b0;
   endtask

   task automatic check_hz(input string tag, input logic [3:0] e_stall,
                           input logic [3:0] e_flush, input logic e_hold);
      check_eq({tag, "_stall"}, 32'(stall), 32'(e_stall));
      check_eq({tag, "_flush"}, 32'(flush), 32'(e_flush));
      check_eq({tag, "_pc_hold"}, 32'(pc_hold), 32'(e_hold));
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      #2;
      check_hz("reset", 4'b0000, 4'b1111, 1'b1);
      check_eq("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      check_eq("reset_flush_cnt", 32'(flush_cnt), 32'd0);
      check_eq("reset_irq_take", 32'(irq_take), 32'd0);
      check_eq("reset_mem_err", 32'(mem_err), 32'd0);
      check_eq("reset_irq_masked", 32'(irq_masked), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check_hz("idle", 4'b0000, 4'b0000, 1'b0);

      // load r3 in EX, ID uses r3
      step();
      ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 4'd3;
      id_rs1 = 4'd3; id_rs1_used = 1'b1; id_rs2 = 4'd9;
      #1;
      check_hz("load_use", 4'b0001, 4'b0010, 1'b1);
      step();
      ex_is_load = 1'b0; ex_reg_wr = 1'b0; ex_rd = 4'd0;
      ex_rs1 = 4'd3; ex_rs2 = 4'd7;
      mem_rd = 4'd3; mem_reg_wr = 1'b1; mem_is_load = 1'b1;
      mem_load_data = 32'hDEADBEEF; mem_alu_data = 32'h12345678;
      #1;
      check_hz("lu_next", 4'b0000, 4'b0000, 1'b0);
      check_eq("lu_rs1_sel", 32'(rs1_fwd_sel), 32'd1);
      check_eq("lu_rs1_data", rs1_fwd_data, 32'hDEADBEEF);
      check_eq("lu_rs2_sel_none", 32'(rs2_fwd_sel), 32'd0);
      check_eq("lu_rs2_data_none", rs2_fwd_data, 32'h0);
      check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      check_eq("lu_flush_cnt", 32'(flush_cnt), 32'd1);

      // MEM and WB both write r5
      step();
      idle_inputs();
      mem_rd = 4'd5; mem_reg_wr = 1'b1; mem_alu_data = 32'hA5A50001;
      mem_load_data = 32'hFFFF0000;
      wb_rd = 4'd5; wb_reg_wr = 1'b1; wb_data = 32'h0BAD0002;
      ex_rs1 = 4'd5; ex_rs2 = 4'd5;
      #1;
      check_eq("mw_rs1_sel", 32'(rs1_fwd_sel), 32'd1);
      check_eq("mw_rs1_data", rs1_fwd_data, 32'hA5A50001);
      check_eq("mw_rs2_data", rs2_fwd_data, 32'hA5A50001);
      step();
      mem_reg_wr = 1'b0;
      #1;
      check_eq("wb_rs2_sel", 32'(rs2_fwd_sel), 32'd2);
      check_eq("wb_rs2_data", rs2_fwd_data, 32'h0BAD0002);
      step();
      mem_rd = 4'd0; mem_reg_wr = 1'b1; wb_rd = 4'd0; wb_reg_wr = 1'b1;
      ex_rs1 = 4'd0;
      ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 4'd0;
      id_rs1 = 4'd0; id_rs1_used = 1'b1;
      #1;
      check_eq("r0_rs1_sel", 32'(rs1_fwd_sel), 32'd0);
      check_eq("r0_rs1_data", rs1_fwd_data, 32'h0);
      check_hz("r0_no_lu", 4'b0000, 4'b0000, 1'b0);

      // memory wait, valid after 4 cycles
      step();
      idle_inputs();
      mem_req = 1'b1;
      for (int unsigned k = 0; k < 4; k++) begin
         if (k != 0) step();
         #1;
         check_hz("mwait", 4'b1111, 4'b0000, 1'b1);
      end
      step();
      mem_valid = 1'b1;
      #1;
      check_hz("mvalid", 4'b0000, 4'b0000, 1'b0);
      step();
      mem_req = 1'b0; mem_valid = 1'b0;
      #1;
      check_eq("mwait_stall_cnt", 32'(stall_cnt), 32'd5);

      // timeout with mem_req held
      step();
      mem_req = 1'b1;
      for (int unsigned k = 0; k < 15; k++) begin
         if (k != 0) step();
         #1;
         check_eq("tmo_stall", 32'(stall), 32'hF);
         check_eq("tmo_no_err", 32'(mem_err), 32'd0);
      end
      step();
      #1;
      check_eq("tmo_err", 32'(mem_err), 32'd1);
      check_eq("tmo_stall_drop", 32'(stall), 32'h0);
      mem_req = 1'b0;
      step();
      #1;
      check_eq("tmo_err_pulse", 32'(mem_err), 32'd0);
      check_eq("tmo_stall_cnt_sat", 32'(stall_cnt), 32'd15);

      // alert during memory wait
      step();
      mem_req = 1'b1; alert = 1'b1;
      #1;
      check_eq("irq_wait_a", 32'(irq_take), 32'd0);
      step();
      alert = 1'b0;
      #1;
      check_eq("irq_wait_b", 32'(irq_take), 32'd0);
      check_eq("irq_wait_mask", 32'(irq_masked), 32'd0);
      step();
      mem_valid = 1'b1;
      #1;
      check_eq("irq_wait_c", 32'(irq_take), 32'd0);
      step();
      mem_req = 1'b0; mem_valid = 1'b0;
      #1;
      check_eq("irq_take1", 32'(irq_take), 32'd1);
      check_eq("irq_take1_mask", 32'(irq_masked), 32'd1);
      check_hz("irq_take1", 4'b0000, 4'b0011, 1'b0);
      step();
      alert = 1'b1;
      #1;
      check_eq("irq_after1", 32'(irq_take), 32'd0);
      check_eq("irq_masked", 32'(irq_masked), 32'd1);
      check_hz("irq_masked", 4'b0000, 4'b0000, 1'b0);
      step();
      alert = 1'b0; reti = 1'b1;
      #1;
      check_eq("irq_latched_no_take", 32'(irq_take), 32'd0);
      step();
      reti = 1'b0;
      #1;
      check_eq("irq_reti_unmask", 32'(irq_masked), 32'd0);
      step();
      #1;
      check_eq("irq_pend2", 32'(irq_take), 32'd0);
      step();
      #1;
      check_eq("irq_take2", 32'(irq_take), 32'd1);
      check_eq("irq_take2_flush", 32'(flush), 32'h3);
      step();
      reti = 1'b1;
      #1;
      check_eq("irq_take2_pulse", 32'(irq_take), 32'd0);
      step();
      reti = 1'b0;
      #1;
      check_eq("irq_flush_cnt", 32'(flush_cnt), 32'd3);

      // priority: branch_miss over load-use, load-use over redirect
      step();
      ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd = 4'd4;
      id_rs2 = 4'd4; id_rs2_used = 1'b1; branch_miss = 1'b1;
      #1;
      check_hz("bm_lu", 4'b0000, 4'b0011, 1'b0);
      step();
      branch_miss = 1'b0; id_redirect = 1'b1;
      #1;
      check_hz("lu_redir", 4'b0001, 4'b0010, 1'b1);
      step();
      idle_inputs();
      id_redirect = 1'b1;
      #1;
      check_hz("redir", 4'b0000, 4'b0001, 1'b0);
      step();
      idle_inputs();
      #1;
      check_eq("prio_flush_cnt", 32'(flush_cnt), 32'd6);
      check_eq("prio_stall_cnt", 32'(stall_cnt), 32'd15);

      // reset in the middle of a memory wait
      step();
      mem_req = 1'b1;
      step();
      #1;
      check_eq("rstw_stall", 32'(stall), 32'hF);
      rst_n = 1'b0;
      #1;
      check_hz("rst_mid", 4'b0000, 4'b1111, 1'b1);
      check_eq("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
      check_eq("rst_mid_flush_cnt", 32'(flush_cnt), 32'd0);
      step();
      mem_req = 1'b0;
      rst_n = 1'b1;
      step();
      #1;
      check_hz("post_rst_idle", 4'b0000, 4'b0000, 1'b0);
      check_eq("post_rst_masked", 32'(irq_masked), 32'd0);
      check_eq("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
